axis_spi_master: RTL

AXIS_SPI_MASTER -- requirements
Module: axis_spi_master

---
 rtl/axis_spi_master_if.sv | 12 +
 rtl/axis_spi_master.sv | 132 +++++++++++++
 2 files changed

// File: rtl/axis_spi_master_if.sv
// AXI-Stream handshake bundle shared by the SPI master's
// transmit and receive word streams.
interface axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_spi_master.sv
// Single-word SPI master: one AXIS word in, one full-duplex frame
// on the wire, one AXIS word out. Modes 0..3, MSB first.
module axis_spi_master #(
    parameter int SPI_MODE   = 1,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic   clk_i,
    input  logic   arst_i,
    output logic   spi_clk_o,
    output logic   spi_cs_o,
    output logic   spi_mosi_o,
    input  logic   spi_miso_i,
    axis_if.slave  s_axis,
    axis_if.master m_axis
);
    localparam bit CPOL = SPI_MODE[1];
    localparam bit CPHA = SPI_MODE[0];
    localparam int CW   = $clog2(CLK_DIV);
    localparam int BW   = $clog2(DATA_WIDTH) + 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] EDGE_LAST = BW'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         edge_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  sclk_q;
    logic                  cs_q;
    logic                  mosi_q;
    logic                  tvalid_q;

    logic cnt_done;
    logic leading;
    logic last_edge;
    logic ready;

    assign cnt_done  = (cnt_q == CNT_LAST);
    assign leading   = ~edge_q[0];
    assign last_edge = (edge_q == EDGE_LAST);
    assign ready     = (state_q == IDLE) && !tvalid_q && !arst_i;

    assign s_axis.tready = ready;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign spi_clk_o     = sclk_q;
    assign spi_cs_o      = cs_q;
    assign spi_mosi_o    = mosi_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            tdata_q  <= '0;
            sclk_q   <= CPOL;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
            cnt_q <= cnt_done ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (s_axis.tvalid && ready) begin
                        state_q <= SETUP;
                        cs_q    <= 1'b0;
                        tx_q    <= s_axis.tdata;
                        rx_q    <= '0;
                        mosi_q  <= CPHA ? 1'b0 : s_axis.tdata[DATA_WIDTH-1];
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        state_q <= XFER;
                        edge_q  <= '0;
                    end
                end
                XFER: begin
                    if (cnt_done) begin
                        sclk_q <= ~sclk_q;
                        edge_q <= last_edge ? '0 : edge_q + 1'b1;
                        // CPHA=0 samples on leading, CPHA=1 on trailing
                        if (leading ^ CPHA) begin
                            rx_q <= {rx_q[DATA_WIDTH-2:0], spi_miso_i};
                        end else if (!last_edge) begin
                            mosi_q <= CPHA ? tx_q[DATA_WIDTH-1]
                                           : tx_q[DATA_WIDTH-2];
                            tx_q   <= tx_q << 1;
                        end
                        if (last_edge) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        state_q  <= GAP;
                        cs_q     <= 1'b1;
                        mosi_q   <= 1'b0;
                        tvalid_q <= 1'b1;
                        tdata_q  <= rx_q;
                    end
                end
                GAP: begin
                    if (cnt_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
